bus_line_xfer: RTL
==================

Name: bus_line_xfer

Overview:
- Parametrised line-transfer engine between a cache/fetch client and the shared system bus.
- Performs either a line fill (read) or a line writeback (write) of LINE_BEATS beats of BUS_DATA_WIDTH each.
- Requests the bus through the arbiter and holds bus ownership for the whole transaction.
- Pulses done when the transfer completes.

Parameters:
- BUS_DATA_WIDTH, 64, width of one bus beat.
- BUS_TAG_WIDTH, 13, width of req/resp tag.
- LINE_BEATS, 8, beats per line (power of two, >=2).
- LINE_WIDTH, BUS_DATA_WIDTH*LINE_BEATS, derived line width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin transfer; sampled only in IDLE
- write  in  1  sampled with start: 1=writeback, 0=fill
- addr  in  BUS_DATA_WIDTH  byte address; line-aligned internally
- wdata  in  LINE_WIDTH  writeback line, sampled with start
- rdata  out  LINE_WIDTH  fill line; beat i at bits [i*W+W-1:i*W]
- done  out  1  one-cycle completion pulse
- busy  out  1  high whenever not IDLE
- abtr_reqcyc  out  1  arbiter request
- abtr_grant  in  1  arbiter grant
- bus_busy  out  1  bus ownership held
- main_bus_reqcyc  out  1  request valid
- main_bus_req  out  BUS_DATA_WIDTH  address/data beat
- main_bus_reqtag  out  BUS_TAG_WIDTH  request tag
- main_bus_respcyc  in  1  response valid
- main_bus_resp  in  BUS_DATA_WIDTH  response beat
- main_bus_resptag  in  BUS_TAG_WIDTH  response tag
- main_bus_respack  out  1  response acknowledge

Behaviour:
- Reset: state IDLE; beat counter 0; rdata 0; all outputs 0. Reset mid-transfer aborts immediately. No partial rdata survives reset.
- States: IDLE, ARB, ADDR, WDATA, RWAIT, DONE.
- IDLE -> ARB on start.
  - Latch write, wdata, and aligned address: addr with the low log2(LINE_WIDTH/8) bits cleared.
  - start is ignored in any other state.
- ARB: abtr_reqcyc=1. Move to ADDR on abtr_grant.
- ADDR (1 cycle):
  - main_bus_reqcyc=1, main_bus_req=aligned address.
  - reqtag = WRITE<<12 | MEMORY<<8 when write, else READ<<12 | MEMORY<<8.
  - Next state: WDATA if write, else RWAIT.
- WDATA: one beat per cycle for LINE_BEATS cycles, beat 0 first.
  - main_bus_reqcyc=1, main_bus_req=beat[cnt], reqtag=write tag.
  - After the last beat, go to DONE.
- RWAIT: a beat is accepted only when respcyc=1 and resptag equals the read tag.
  - On accept: respack=1 combinationally in the same cycle; store resp into rdata slot cnt; cnt++.
  - Non-matching tag or respcyc=0: respack=0, nothing captured.
  - Gaps between beats are allowed.
  - On accept of beat LINE_BEATS-1, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. rdata is stable from DONE until the next fill's first accepted beat.
- bus_busy=1 from ADDR through DONE inclusive; 0 in IDLE and ARB. busy=1 in every state except IDLE.
- main_bus_req and main_bus_reqtag are 0 whenever reqcyc=0. All outputs are registered or decoded from the current state (no next-state decoding).
- Counter width $clog2(LINE_BEATS)+1; cleared on entering ADDR.
- Minimum latency from start:
  - Read with grant held high and back-to-back beats: 3+LINE_BEATS cycles to done.
  - Write: 3+LINE_BEATS cycles.

Decomposition:
- Shared package sysbus_pkg: SYSBUS_READ, SYSBUS_WRITE, SYSBUS_MEMORY constants; tag-build function; xfer_state_t enum.
- One natural sub-module, line_beat_buf: LINE_BEATS-slot register file with beat write-enable/index, full-line load, and beat select for writeback.

Test Plan:
- Fill, grant immediate, 8 back-to-back beats 0x11..0x88, addr=0x1234 -> req=0x1200, reqtag=0x1100, rdata slot i = beat i, done at cycle 11.
- Fill with foreign-tag beat (0x1500) interleaved -> respack=0 that cycle, beat not captured, rdata unchanged by it.
- Fill with grant delayed 5 cycles and 2-cycle gaps between beats -> abtr_reqcyc held through ARB, bus_busy 0 until ADDR, correct line.
- Writeback of wdata beats 0xA0..0xA7, addr=0x40 -> ADDR beat req=0x40, reqtag=WRITE tag, then 8 reqcyc beats in order, done pulse once.
- Reset asserted at beat 4 of a fill -> next cycle IDLE, all outputs 0, rdata 0; new start completes normally.
- start pulsed while busy -> ignored; exactly one done for the original transfer.

Source files
------------

// File: rtl/sysbus_pkg.sv
// Shared system-bus definitions: request opcodes, device codes, tag packing
// and the line-transfer state encoding.
package sysbus_pkg;

  localparam logic [3:0] SYSBUS_READ   = 4'h1;
  localparam logic [3:0] SYSBUS_WRITE  = 4'h0;
  localparam logic [3:0] SYSBUS_MEMORY = 4'h1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_RWAIT = 3'd4,
    ST_DONE  = 3'd5
  } xfer_state_t;

  // Tag layout: opcode in [15:12], target device in [11:8], low byte zero.
  function automatic logic [15:0] sysbus_tag(input logic [3:0] op, input logic [3:0] dev);
    return {op, dev, 8'h00};
  endfunction

endpackage

// File: rtl/line_beat_buf.sv
// Line-sized register file organised as BEATS slots: single-beat writes,
// whole-line loads, packed line view and a per-beat read port.
module line_beat_buf #(
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          beat_we,
  input  logic [$clog2(BEATS)-1:0]      beat_idx,
  input  logic [BEAT_WIDTH-1:0]         beat_in,
  input  logic                          line_load,
  input  logic [BEAT_WIDTH*BEATS-1:0]   line_in,
  output logic [BEAT_WIDTH*BEATS-1:0]   line,
  output logic [BEAT_WIDTH-1:0]         beat_out
);

  logic [BEAT_WIDTH-1:0] slots [BEATS];

  // NOTE: this storage is reset on purpose so no stale line is ever visible
  // after an aborted transfer; a plain RAM without reset would not allow that.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BEATS; i++) slots[i] <= '0;
    end else if (line_load) begin
      for (int i = 0; i < BEATS; i++) slots[i] <= line_in[i*BEAT_WIDTH +: BEAT_WIDTH];
    end else if (beat_we) begin
      slots[beat_idx] <= beat_in;
    end
  end

  // NOTE: default assignment first so the combinational block cannot infer a latch.
  always_comb begin
    line = '0;
    for (int i = 0; i < BEATS; i++) line[i*BEAT_WIDTH +: BEAT_WIDTH] = slots[i];
  end

  assign beat_out = slots[beat_idx];

endmodule

// File: rtl/bus_line_xfer.sv
// Line fill / writeback engine: arbitrates for the system bus, issues the
// line address, then streams LINE_BEATS beats out (write) or in (read).
module bus_line_xfer
  import sysbus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8,
  parameter int LINE_WIDTH     = BUS_DATA_WIDTH * LINE_BEATS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      write,
  input  logic [BUS_DATA_WIDTH-1:0] addr,
  input  logic [LINE_WIDTH-1:0]     wdata,
  output logic [LINE_WIDTH-1:0]     rdata,
  output logic                      done,
  output logic                      busy,
  output logic                      abtr_reqcyc,
  input  logic                      abtr_grant,
  output logic                      bus_busy,
  output logic                      main_bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] main_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  main_bus_reqtag,
  input  logic                      main_bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] main_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  main_bus_resptag,
  output logic                      main_bus_respack
);

  localparam int IDX_W = $clog2(LINE_BEATS);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);

  localparam logic [BUS_DATA_WIDTH-1:0] ALIGN_MASK =
    ~((BUS_DATA_WIDTH'(1) << OFF_W) - BUS_DATA_WIDTH'(1));
  localparam logic [BUS_TAG_WIDTH-1:0] RD_TAG =
    BUS_TAG_WIDTH'(sysbus_tag(SYSBUS_READ, SYSBUS_MEMORY));
  localparam logic [BUS_TAG_WIDTH-1:0] WR_TAG =
    BUS_TAG_WIDTH'(sysbus_tag(SYSBUS_WRITE, SYSBUS_MEMORY));
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

  xfer_state_t               state;
  logic [CNT_W-1:0]          cnt;
  logic                      write_q;
  logic [BUS_DATA_WIDTH-1:0] addr_q;
  logic                      accept;
  logic                      wb_load;
  logic [BUS_DATA_WIDTH-1:0] wb_beat;
  logic [BUS_DATA_WIDTH-1:0] fill_beat_unused;
  logic [LINE_WIDTH-1:0]     wb_line_unused;

  assign accept  = (state == ST_RWAIT) && main_bus_respcyc && (main_bus_resptag == RD_TAG);
  assign wb_load = (state == ST_IDLE) && start && write;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          write_q <= write;
          addr_q  <= addr & ALIGN_MASK;
          state   <= ST_ARB;
        end
        ST_ARB: if (abtr_grant) begin
          cnt   <= '0;
          state <= ST_ADDR;
        end
        ST_ADDR: state <= write_q ? ST_WDATA : ST_RWAIT;
        ST_WDATA: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_BEAT) state <= ST_DONE;
        end
        ST_RWAIT: if (accept) begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_BEAT) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Separate fill and writeback storage keeps rdata untouched by writebacks.
  line_beat_buf #(.BEAT_WIDTH(BUS_DATA_WIDTH), .BEATS(LINE_BEATS)) u_fill_buf (
    .clk       (clk),
    .reset     (reset),
    .beat_we   (accept),
    .beat_idx  (cnt[IDX_W-1:0]),
    .beat_in   (main_bus_resp),
    .line_load (1'b0),
    .line_in   ({LINE_WIDTH{1'b0}}),
    .line      (rdata),
    .beat_out  (fill_beat_unused)
  );

  line_beat_buf #(.BEAT_WIDTH(BUS_DATA_WIDTH), .BEATS(LINE_BEATS)) u_wb_buf (
    .clk       (clk),
    .reset     (reset),
    .beat_we   (1'b0),
    .beat_idx  (cnt[IDX_W-1:0]),
    .beat_in   ({BUS_DATA_WIDTH{1'b0}}),
    .line_load (wb_load),
    .line_in   (wdata),
    .line      (wb_line_unused),
    .beat_out  (wb_beat)
  );

  assign busy             = (state != ST_IDLE);
  assign done             = (state == ST_DONE);
  assign abtr_reqcyc      = (state == ST_ARB);
  assign bus_busy         = (state == ST_ADDR) || (state == ST_WDATA) ||
                            (state == ST_RWAIT) || (state == ST_DONE);
  assign main_bus_reqcyc  = (state == ST_ADDR) || (state == ST_WDATA);
  assign main_bus_respack = accept;

  always_comb begin
    main_bus_req    = '0;
    main_bus_reqtag = '0;
    if (state == ST_ADDR) begin
      main_bus_req    = addr_q;
      main_bus_reqtag = write_q ? WR_TAG : RD_TAG;
    end else if (state == ST_WDATA) begin
      main_bus_req    = wb_beat;
      main_bus_reqtag = WR_TAG;
    end
  end

endmodule
